// File: rtl/pcw_boot_mem_sequencer.sv
// Boot memory sequencer: copies the boot ROM into RAM from address 0 after
// start, shares the RAM write port with single-entry-buffered HPS download
// writes, holds the CPU off during the copy and pulses execute_enable at the end.
module pcw_boot_mem_sequencer #(
    parameter int unsigned BOOT_ROM_END = 275,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned ROM_LAT      = 1
) (
    input  logic              clk_sys_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    input  logic              dl_wr_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [7:0]        dl_data_i,
    output logic              dl_wait_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic              mem_ack_i,
    output logic              cpu_hold_o,
    output logic              execute_enable_o,
    output logic              dl_overflow_o
);

    localparam int unsigned LAT_W  = 2;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE_BOOT,
        S_GRANT_DL,
        S_WRITE_DL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_req_q, mem_req_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                exec_q, exec_d;
    logic                restart_q, restart_d;
    logic                full_q, full_d;
    logic [ADDR_W-1:0]   dl_addr_q, dl_addr_d;
    logic [DATA_W-1:0]   dl_data_q, dl_data_d;
    logic                ovf_q, ovf_d;
    logic                restart_now;
    logic                dl_pend_now;

    // A start pulse this cycle or one latched while busy both request a (re)start.
    assign restart_now = restart_q | start_i;
    // A download accepted in the ack cycle still gets the next slot.
    assign dl_pend_now = full_q | dl_wr_i;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lat_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_req_q  <= 1'b0;
            cpu_hold_q <= 1'b0;
            exec_q     <= 1'b0;
            restart_q  <= 1'b0;
            full_q     <= 1'b0;
            dl_addr_q  <= '0;
            dl_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_req_q  <= mem_req_d;
            cpu_hold_q <= cpu_hold_d;
            exec_q     <= exec_d;
            restart_q  <= restart_d;
            full_q     <= full_d;
            dl_addr_q  <= dl_addr_d;
            dl_data_q  <= dl_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state, download buffer and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cpu_hold_d = cpu_hold_q;
        exec_d     = 1'b0;
        restart_d  = restart_q;
        full_d     = full_q;
        dl_addr_d  = dl_addr_q;
        dl_data_d  = dl_data_q;
        ovf_d      = ovf_q | (dl_wr_i & full_q);

        if (dl_wr_i && !full_q) begin
            full_d    = 1'b1;
            dl_addr_d = dl_addr_i;
            dl_data_d = dl_data_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (restart_now) begin
                    state_d    = S_FETCH;
                    cnt_d      = '0;
                    lat_d      = '0;
                    cpu_hold_d = 1'b1;
                    restart_d  = 1'b0;
                end else if (full_q) begin
                    state_d = S_GRANT_DL;
                end
            end
            S_FETCH: begin
                if (restart_now) begin
                    cnt_d     = '0;
                    lat_d     = '0;
                    restart_d = 1'b0;
                end else if (lat_q == LAT_W'(ROM_LAT)) begin
                    mem_addr_d = cnt_q;
                    mem_data_d = rom_data_i;
                    lat_d      = '0;
                    state_d    = S_WRITE_BOOT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE_BOOT: begin
                if (mem_ack_i) begin
                    lat_d = '0;
                    if (!restart_now && (cnt_q == ADDR_W'(BOOT_ROM_END))) begin
                        state_d    = S_DONE;
                        cpu_hold_d = 1'b0;
                        exec_d     = 1'b1;
                    end else begin
                        cnt_d     = restart_now ? '0 : cnt_q + ADDR_W'(1);
                        restart_d = 1'b0;
                        state_d   = dl_pend_now ? S_GRANT_DL : S_FETCH;
                    end
                end else if (start_i) begin
                    restart_d = 1'b1;
                end
            end
            S_GRANT_DL: begin
                mem_addr_d = dl_addr_q;
                mem_data_d = dl_data_q;
                full_d     = 1'b0;
                state_d    = S_WRITE_DL;
                if (start_i) begin
                    restart_d = 1'b1;
                end
            end
            S_WRITE_DL: begin
                if (mem_ack_i) begin
                    lat_d = '0;
                    if (restart_now) begin
                        cnt_d      = '0;
                        cpu_hold_d = 1'b1;
                        restart_d  = 1'b0;
                        state_d    = S_FETCH;
                    end else if (cpu_hold_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (start_i) begin
                    restart_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    restart_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_req_d = (state_d == S_WRITE_BOOT) || (state_d == S_WRITE_DL);
    end

    assign rom_addr_o       = cnt_q;
    assign dl_wait_o        = full_q;
    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_data_o       = mem_data_q;
    assign cpu_hold_o       = cpu_hold_q;
    assign execute_enable_o = exec_q;
    assign dl_overflow_o    = ovf_q;

endmodule

// File: tb/tb_pcw_boot_mem_sequencer.sv
// Self-checking bench for pcw_boot_mem_sequencer: ROM and RAM models,
// expected-write scoreboard, basic/contention/overflow/slow/restart/reset cases.
module tb_pcw_boot_mem_sequencer;

    localparam int unsigned END_A  = 275;
    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ack;
    logic              cpu_hold;
    logic              exec_en;
    logic              dl_overflow;

    pcw_boot_mem_sequencer #(
        .BOOT_ROM_END(END_A),
        .ADDR_W      (ADDR_W),
        .ROM_LAT     (1)
    ) dut (
        .clk_sys_i       (clk),
        .reset_i         (reset),
        .start_i         (start),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .dl_wr_i         (dl_wr),
        .dl_addr_i       (dl_addr),
        .dl_data_i       (dl_data),
        .dl_wait_o       (dl_wait),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data),
        .mem_ack_i       (mem_ack),
        .cpu_hold_o      (cpu_hold),
        .execute_enable_o(exec_en),
        .dl_overflow_o   (dl_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd37;
        return t ^ a[15:8] ^ 8'h5C;
    endfunction

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) rom_data <= rom_byte(rom_addr);

    // RAM responder: ack after ack_dly cycles of request, or forced.
    int unsigned ack_dly = 0;
    bit          ack_en = 1'b1;
    bit          ack_force = 1'b0;
    int unsigned age = 0;
    assign mem_ack = (mem_req && ack_en && (age == ack_dly)) || ack_force;
    always @(posedge clk) age <= (mem_req && !mem_ack) ? age + 1 : 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_wr = 0;
    int unsigned n_exec = 0;
    int unsigned exec_cyc = 0;
    bit          chk_stable = 1'b0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write monitor / scoreboard consumer, exec pulse and stability checks.
    initial begin
        logic [23:0]       e;
        bit                prev_open;
        logic [ADDR_W-1:0] prev_a;
        logic [7:0]        prev_d;
        prev_open = 1'b0;
        prev_a    = '0;
        prev_d    = '0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_ack) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {8'h00, mem_addr, mem_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {8'h00, mem_addr, mem_data}, {8'h00, e});
                end
            end
            if (exec_en) begin
                n_exec++;
                exec_cyc = cyc;
                check("hold_low_at_exec", 32'(cpu_hold), 32'd0);
            end
            if (chk_stable) begin
                if (prev_open && mem_req) begin
                    check("addr_stable", 32'(mem_addr), 32'(prev_a));
                    check("data_stable", 32'(mem_data), 32'(prev_d));
                end
                prev_open = mem_req && !mem_ack;
                prev_a    = mem_addr;
                prev_d    = mem_data;
            end else begin
                prev_open = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_boot(input int unsigned lo, input int unsigned hi);
        for (int unsigned a = lo; a <= hi; a++) begin
            exp_q.push_back({16'(a), rom_byte(16'(a))});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_exec(input int unsigned max_cyc, input string tag);
        int unsigned n0;
        bit          seen;
        n0   = n_exec;
        seen = 1'b0;
        for (int unsigned i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (n_exec != n0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_boot_req(input logic [15:0] a, input string tag);
        bit seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < 4000 && !seen; i++) begin
            if (mem_req && cpu_hold && (mem_addr == a)) seen = 1'b1;
            else tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int unsigned t0;
        int unsigned w0;
        int unsigned e0;
        bit          seen;
        reset = 1'b1;
        start = 1'b0;
        dl_wr = 1'b0;
        dl_addr = '0;
        dl_data = '0;
        repeat (3) tick();

        // Reset state
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_exec", 32'(exec_en), 32'd0);
        check("rst_dl_wait", 32'(dl_wait), 32'd0);
        check("rst_overflow", 32'(dl_overflow), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        tick();

        // Basic copy
        w0 = n_wr;
        e0 = n_exec;
        push_boot(0, END_A);
        t0 = cyc;
        pulse_start();
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        wait_exec(2000, "basic_exec_seen");
        check("basic_exec_cycle", exec_cyc - t0, 32'd829);
        repeat (4) tick();
        check("basic_writes", n_wr - w0, 32'd276);
        check("basic_exec_count", n_exec - e0, 32'd1);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
        check("basic_hold_after", 32'(cpu_hold), 32'd0);

        // Contention: download during boot byte 10
        e0 = n_exec;
        push_boot(0, 10);
        exp_q.push_back({16'h8000, 8'h5A});
        push_boot(11, END_A);
        pulse_start();
        wait_boot_req(16'd10, "cont_byte10_seen");
        dl_wr = 1'b1;
        dl_addr = 16'h8000;
        dl_data = 8'h5A;
        tick();
        dl_wr = 1'b0;
        check("cont_dl_wait_high", 32'(dl_wait), 32'd1);
        tick();
        check("cont_dl_wait_low", 32'(dl_wait), 32'd0);
        check("cont_dl_req", 32'(mem_req), 32'd1);
        check("cont_dl_addr", 32'(mem_addr), 32'h8000);
        wait_exec(2000, "cont_exec_seen");
        repeat (4) tick();
        check("cont_exec_count", n_exec - e0, 32'd1);
        check("cont_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: two back-to-back downloads while idle
        w0 = n_wr;
        exp_q.push_back({16'h1234, 8'hA5});
        dl_wr = 1'b1;
        dl_addr = 16'h1234;
        dl_data = 8'hA5;
        tick();
        dl_addr = 16'h4321;
        dl_data = 8'h3C;
        tick();
        dl_wr = 1'b0;
        check("ovf_set", 32'(dl_overflow), 32'd1);
        repeat (10) tick();
        check("ovf_sticky", 32'(dl_overflow), 32'd1);
        check("ovf_writes", n_wr - w0, 32'd1);
        check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        check("ovf_cleared", 32'(dl_overflow), 32'd0);

        // Slow RAM
        ack_dly = 5;
        chk_stable = 1'b1;
        w0 = n_wr;
        e0 = n_exec;
        push_boot(0, END_A);
        pulse_start();
        wait_exec(6000, "slow_exec_seen");
        repeat (10) tick();
        chk_stable = 1'b0;
        ack_dly = 0;
        check("slow_writes", n_wr - w0, 32'd276);
        check("slow_exec_count", n_exec - e0, 32'd1);
        check("slow_queue_empty", 32'(exp_q.size()), 32'd0);

        // Restart at boot byte 100
        w0 = n_wr;
        e0 = n_exec;
        push_boot(0, 100);
        push_boot(0, END_A);
        pulse_start();
        wait_boot_req(16'd100, "rst_byte100_seen");
        pulse_start();
        wait_exec(2000, "restart_exec_seen");
        repeat (900) tick();
        check("restart_writes", n_wr - w0, 32'd377);
        check("restart_exec_count", n_exec - e0, 32'd1);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write
        ack_en = 1'b0;
        w0 = n_wr;
        e0 = n_exec;
        pulse_start();
        seen = 1'b0;
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else tick();
        end
        check("midw_req_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        tick();
        check("midw_req_dropped", 32'(mem_req), 32'd0);
        reset = 1'b0;
        check("midw_hold", 32'(cpu_hold), 32'd0);
        check("midw_mem_data", 32'(mem_data), 32'd0);
        check("midw_rom_addr", 32'(rom_addr), 32'd0);
        ack_en = 1'b1;
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        repeat (3) tick();
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_hold", 32'(cpu_hold), 32'd0);
        check("late_ack_rom_addr", 32'(rom_addr), 32'd0);
        check("late_ack_dl_wait", 32'(dl_wait), 32'd0);
        check("late_ack_writes", n_wr - w0, 32'd0);
        check("late_ack_exec", n_exec - e0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
